// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector MEM-stage sequencer.
// The optional stall counter is enabled with VEC_MEM_STALL_COUNT_EN.
package vec_mem_pkg;

  localparam int LANES  = 16;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 19;
  localparam int IDX_W  = 4;

  typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } vms_state_t;

endpackage

// File: rtl/vec_lane_counter.sv
// Lane index counter: 0..LANES-1 with synchronous clear, count enable and
// a terminal-count flag on the last lane.
module vec_lane_counter
  import vec_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign tc = (idx == IDX_W'(LANES - 1));

endmodule

// File: rtl/vec_mem_sequencer.sv
// MEM-stage controller: serialises vector stores and gathers vector loads
// over a 16-bit RAM port, stalling the pipeline meanwhile.
// Define VEC_MEM_STALL_COUNT_EN to add the saturating stall_cycles output.
//
// Handshake: a request is accepted in IDLE in the same cycle a start_* is
// high (stall rises combinationally that cycle); the result is presented for
// exactly one cycle in DONE, where start_* is ignored.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        rd_in,
  input  vec_t              store_vec,
  input  logic [ELEM_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ELEM_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              stall,
  output logic              busy,
  output logic              load_valid,
  output vec_t              load_vec,
  output logic [4:0]        load_rd,
  output vms_state_t        dbg_state
`ifdef VEC_MEM_STALL_COUNT_EN
  ,
  output logic [ADDR_W-1:0] stall_cycles
`endif
);

  vms_state_t        state, nxt_state;
  logic [ADDR_W-1:0] base_q;
  vec_t              store_q;
  logic [4:0]        rd_q;
  logic              op_load_q;
  vec_t              gather_q, gather_nxt;
  logic [ADDR_W-1:0] addr_hold;
  logic [ELEM_W-1:0] wdata_hold;
  logic [RD_LAT-1:0] cap_pipe;

  logic [IDX_W-1:0]  iss_idx, cap_idx;
  logic              iss_tc, cap_tc;
  logic              issue_en, cap_en, last_cap, start_seen;
  logic [ADDR_W-1:0] iss_addr;

  assign start_seen = (state == IDLE) && (start_store || start_load);
  assign issue_en   = (state == STORE) || (state == LOAD);
  assign iss_addr   = base_q + ADDR_W'(iss_idx);
  // A read issued in LOAD returns RD_LAT cycles later; the pipe tracks which
  // cycles carry valid return data.
  assign cap_en     = cap_pipe[RD_LAT-1];
  assign last_cap   = cap_en && cap_tc;

  vec_lane_counter u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  (issue_en),
    .idx (iss_idx),
    .tc  (iss_tc)
  );

  vec_lane_counter u_capture_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  (cap_en),
    .idx (cap_idx),
    .tc  (cap_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (start_store) begin
          nxt_state = STORE;
        end else if (start_load) begin
          nxt_state = LOAD;
        end
      end
      STORE: if (iss_tc) nxt_state = DONE;
      LOAD:  if (iss_tc) nxt_state = DRAIN;
      DRAIN: if (last_cap) nxt_state = DONE;
      DONE:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    gather_nxt = gather_q;
    if (cap_en) begin
      gather_nxt[cap_idx] = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      op_load_q  <= 1'b0;
      gather_q   <= '0;
      load_vec   <= '0;
      load_rd    <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      cap_pipe   <= '0;
    end else begin
      if (start_seen) begin
        base_q <= base_addr;
        if (start_store) begin
          store_q   <= store_vec;
          op_load_q <= 1'b0;
        end else begin
          rd_q      <= rd_in;
          op_load_q <= 1'b1;
        end
      end
      cap_pipe <= (cap_pipe << 1) | RD_LAT'(state == LOAD);
      gather_q <= gather_nxt;
      // Publish the whole vector on the final capture so it is stable in DONE.
      if (last_cap) begin
        load_vec <= gather_nxt;
        load_rd  <= rd_q;
      end
      if (issue_en) begin
        addr_hold <= iss_addr;
      end
      if (state == STORE) begin
        wdata_hold <= store_q[iss_idx];
      end
    end
  end

  assign mem_addr   = issue_en ? iss_addr : addr_hold;
  assign mem_wdata  = (state == STORE) ? store_q[iss_idx] : wdata_hold;
  assign mem_wren   = (state == STORE);
  assign stall      = start_seen || issue_en || (state == DRAIN);
  assign busy       = (state != IDLE);
  assign load_valid = (state == DONE) && op_load_q;
  assign dbg_state  = state;

`ifdef VEC_MEM_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + ADDR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed plus randomized bench for vec_mem_sequencer with a RAM model
// (read latency 1) and a shadow memory used as the reference.
module tb_vec_mem_sequencer;
  import vec_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_load = 1'b0;
  logic              start_store = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [4:0]        rd_in = '0;
  vec_t              store_vec = '0;
  logic [ELEM_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              stall;
  logic              busy;
  logic              load_valid;
  vec_t              load_vec;
  logic [4:0]        load_rd;
  vms_state_t        dbg_state;
`ifdef VEC_MEM_STALL_COUNT_EN
  logic [ADDR_W-1:0] stall_cycles;
`endif

  vec_mem_sequencer #(.RD_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_load  (start_load),
    .start_store (start_store),
    .base_addr   (base_addr),
    .rd_in       (rd_in),
    .store_vec   (store_vec),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wren    (mem_wren),
    .stall       (stall),
    .busy        (busy),
    .load_valid  (load_valid),
    .load_vec    (load_vec),
    .load_rd     (load_rd),
    .dbg_state   (dbg_state)
`ifdef VEC_MEM_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // RAM model: one-cycle registered read; bench preload port has priority.
  logic [ELEM_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [ELEM_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [ELEM_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_wren === 1'b1) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  // monitor
  int cyc = 0;
  int stall_cnt = 0;
  int lv_cnt = 0;
  int lv_cyc = -1;
  logic [ADDR_W+ELEM_W-1:0] wr_q[$];
  logic [ADDR_W+ELEM_W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_wren === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
      if (stall === 1'b1) stall_cnt++;
      if (load_valid === 1'b1) begin
        lv_cnt++;
        lv_cyc = cyc;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    stall_cnt = 0;
    lv_cnt = 0;
    lv_cyc = -1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [ELEM_W-1:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_mem[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Issues one request and returns the start cycle and the DONE cycle.
  task automatic run_op(input bit do_store, input bit do_load, input logic [ADDR_W-1:0] base,
                        input vec_t vec, input logic [4:0] rd, input bit hold_starts,
                        output int t0, output int t_done);
    bit seen;
    clear_mon();
    start_store = do_store;
    start_load  = do_load;
    base_addr   = base;
    store_vec   = vec;
    rd_in       = rd;
    t0 = cyc;
    t_done = -1;
    @(negedge clk);
    chk("stall_on_start", 256'(stall), 256'(1));
    if (!hold_starts) begin
      tick();
      start_store = 1'b0;
      start_load  = 1'b0;
    end
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (dbg_state == DONE) begin
        seen = 1'b1;
        t_done = cyc;
      end
    end
    chk("done_reached", 256'(seen), 256'(1));
    tick();
    start_store = 1'b0;
    start_load  = 1'b0;
    @(negedge clk);
    chk("idle_after_done", 256'(busy), 256'(0));
  endtask

  task automatic check_store(input string tag, input logic [ADDR_W-1:0] base, input vec_t vec,
                             input int t0, input int t_done);
    exp_q.delete();
    for (int k = 0; k < LANES; k++) begin
      exp_q.push_back({ADDR_W'(base + ADDR_W'(k)), vec[k]});
      ref_mem[ADDR_W'(base + ADDR_W'(k))] = vec[k];
    end
    chk({tag, "_nwrites"}, 256'(wr_q.size()), 256'(LANES));
    for (int k = 0; k < LANES && k < wr_q.size(); k++) begin
      chk({tag, "_write"}, 256'(wr_q[k]), 256'(exp_q[k]));
    end
    chk({tag, "_stall_len"}, 256'(stall_cnt), 256'(17));
    chk({tag, "_done_cycle"}, 256'(t_done - t0), 256'(17));
    chk({tag, "_no_load_valid"}, 256'(lv_cnt), 256'(0));
  endtask

  task automatic check_load(input string tag, input logic [ADDR_W-1:0] base, input logic [4:0] rd,
                            input int t0);
    vec_t exp_vec;
    for (int k = 0; k < LANES; k++) begin
      exp_vec[k] = ref_mem[ADDR_W'(base + ADDR_W'(k))];
    end
    chk({tag, "_no_writes"}, 256'(wr_q.size()), 256'(0));
    chk({tag, "_valid_pulses"}, 256'(lv_cnt), 256'(1));
    chk({tag, "_valid_cycle"}, 256'(lv_cyc - t0), 256'(18));
    chk({tag, "_stall_len"}, 256'(stall_cnt), 256'(18));
    chk({tag, "_vec"}, 256'(load_vec), 256'(exp_vec));
    chk({tag, "_rd"}, 256'(load_rd), 256'(rd));
  endtask

  initial begin
    int t0, t_done;
    vec_t v, last_vec;
    logic [ADDR_W-1:0] b, lb;
    logic [4:0] r;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 256'(dbg_state), 256'(IDLE));
    chk("rst_outputs", 256'({mem_addr, mem_wdata, mem_wren, stall, busy, load_valid, load_rd}), 256'(0));
    chk("rst_load_vec", 256'(load_vec), 256'(0));
    rst = 1'b1;
    tick();

    // directed store: lane k = 0x1000+k at 0x00100
    for (int k = 0; k < LANES; k++) v[k] = 16'h1000 + 16'(k);
    run_op(1'b1, 1'b0, 19'h00100, v, 5'd0, 1'b0, t0, t_done);
    check_store("store", 19'h00100, v, t0, t_done);

    // directed load from preloaded 0x200 region
    for (int k = 0; k < LANES; k++) preload(19'h00200 + 19'(k), 16'hA000 + 16'(k));
    run_op(1'b0, 1'b1, 19'h00200, '0, 5'd5, 1'b0, t0, t_done);
    check_load("load", 19'h00200, 5'd5, t0);
`ifdef VEC_MEM_STALL_COUNT_EN
    chk("stall_cycles", 256'(stall_cycles), 256'(35));
`endif

    // wrap across the top of the address space
    preload(19'h7FFFE, 16'hBEEF);
    preload(19'h7FFFF, 16'hCAFE);
    for (int k = 0; k < 14; k++) preload(19'(k), 16'h5000 + 16'(k));
    run_op(1'b0, 1'b1, 19'h7FFFE, '0, 5'd31, 1'b0, t0, t_done);
    check_load("wrap_load", 19'h7FFFE, 5'd31, t0);
    last_vec = load_vec;

    // both starts high and held through DONE: store only, no retrigger
    for (int k = 0; k < LANES; k++) v[k] = 16'($urandom);
    run_op(1'b1, 1'b1, 19'h03000, v, 5'd9, 1'b1, t0, t_done);
    check_store("both_start", 19'h03000, v, t0, t_done);
    repeat (4) @(negedge clk);
    chk("both_no_retrigger", 256'(wr_q.size()), 256'(LANES));
    chk("load_vec_hold", 256'(load_vec), 256'(last_vec));

    // randomized store followed by an overlapping load
    for (int it = 0; it < 10; it++) begin
      b = 19'($urandom);
      if ($urandom_range(0, 3) == 0) b = 19'h7FFF0 + 19'($urandom_range(0, 15));
      for (int k = 0; k < LANES; k++) v[k] = 16'($urandom);
      run_op(1'b1, 1'b0, b, v, 5'd0, 1'b0, t0, t_done);
      check_store("rand_store", b, v, t0, t_done);
      lb = b + 19'($urandom_range(0, 8));
      r = 5'($urandom);
      run_op(1'b0, 1'b1, lb, '0, r, 1'b0, t0, t_done);
      check_load("rand_load", lb, r, t0);
    end

    // asynchronous reset in the middle of a load
    clear_mon();
    start_load = 1'b1;
    base_addr  = 19'h00200;
    rd_in      = 5'd7;
    tick();
    start_load = 1'b0;
    repeat (7) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_state", 256'(dbg_state), 256'(IDLE));
    chk("midrst_outputs", 256'({mem_addr, mem_wdata, mem_wren, stall, busy, load_valid, load_rd}), 256'(0));
    chk("midrst_load_vec", 256'(load_vec), 256'(0));
    tick();
    rst = 1'b1;
    clear_mon();
    repeat (20) tick();
    chk("postrst_idle", 256'(busy), 256'(0));
    chk("postrst_no_writes", 256'(wr_q.size()), 256'(0));
    chk("postrst_no_stall", 256'(stall_cnt), 256'(0));
    chk("postrst_no_valid", 256'(lv_cnt), 256'(0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
